// File: rtl/bsg_wormhole_router_output_control.sv
// Output-port controller for the wormhole router: round-robin header
// arbitration among input ports, grant locked to the winner until its packet drains.
module bsg_wormhole_router_output_control #(
  parameter int unsigned input_dirs_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [input_dirs_p-1:0] reqs_i,
  input  logic [input_dirs_p-1:0] release_i,
  input  logic [input_dirs_p-1:0] valid_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [input_dirs_p-1:0] grant_o,
  output logic [input_dirs_p-1:0] yumi_o,
  output logic                    busy_o
);

  localparam int unsigned ptr_w = (input_dirs_p > 1) ? $clog2(input_dirs_p) : 1;
  localparam int unsigned sum_w = ptr_w + 1;

  typedef enum logic [1:0] {IDLE, PEND, LOCK} state_e;

  state_e                  state_r;
  logic [ptr_w-1:0]        ptr_r;
  logic [ptr_w-1:0]        owner_r;
  logic [input_dirs_p-1:0] grant_r;

  logic                    owner_release;
  logic                    owner_valid;
  logic                    free;
  logic                    win_found;
  logic [ptr_w-1:0]        win_idx;
  logic [input_dirs_p-1:0] win_oh;

  // Index one past i, wrapping explicitly for non-power-of-2 port counts
  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] i);
    return (i == ptr_w'(input_dirs_p - 1)) ? '0 : i + ptr_w'(1);
  endfunction

  assign owner_release = |(grant_r & release_i);
  assign owner_valid   = |(grant_r & valid_i);
  assign free          = (state_r == IDLE) || ((state_r == LOCK) && owner_release);

  // Round-robin pick: rotate requests so the pointer sits at bit 0, take first set bit
  always_comb begin
    logic [2*input_dirs_p-1:0] dbl;
    logic [input_dirs_p-1:0]   tmp;
    logic [ptr_w-1:0]          off;
    logic [sum_w-1:0]          sum;
    dbl       = {reqs_i, reqs_i};
    tmp       = input_dirs_p'(dbl >> ptr_r);
    off       = '0;
    win_found = 1'b0;
    for (int i = 0; i < int'(input_dirs_p); i++) begin
      if (!win_found && tmp[0]) begin
        win_found = 1'b1;
        off       = ptr_w'(i);
      end
      tmp = tmp >> 1;
    end
    sum = {1'b0, ptr_r} + {1'b0, off};
    if (sum >= sum_w'(input_dirs_p)) begin
      sum = sum - sum_w'(input_dirs_p);
    end
    win_idx = ptr_w'(sum);
    win_oh  = win_found ? (input_dirs_p'(1) << win_idx) : '0;
  end

  // Crossbar select, downstream valid and dequeue; forced quiet while in reset
  always_comb begin
    valid_o = 1'b0;
    grant_o = '0;
    yumi_o  = '0;
    if (!reset_i) begin
      if (free) begin
        grant_o = win_oh;
        valid_o = win_found;
        yumi_o  = ready_i ? win_oh : '0;
      end else if (state_r == PEND) begin
        grant_o = grant_r;
        valid_o = 1'b1;
        yumi_o  = ready_i ? grant_r : '0;
      end else begin
        grant_o = grant_r;
        valid_o = owner_valid;
        yumi_o  = (owner_valid && ready_i) ? grant_r : '0;
      end
    end
  end

  assign busy_o = (state_r != IDLE);

  // Ownership state, grant register and round-robin pointer
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      owner_r <= '0;
      grant_r <= '0;
    end else if (free) begin
      if (win_found) begin
        grant_r <= win_oh;
        owner_r <= win_idx;
        if (ready_i) begin
          state_r <= LOCK;
          ptr_r   <= next_ptr(win_idx);
        end else begin
          state_r <= PEND;
        end
      end else begin
        state_r <= IDLE;
        grant_r <= '0;
      end
    end else if ((state_r == PEND) && ready_i) begin
      state_r <= LOCK;
      ptr_r   <= next_ptr(owner_r);
    end
  end

  // A header request implies the input FIFO holds a flit
  a_req_has_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    (reqs_i & ~valid_i) == '0);

endmodule

// File: tb/tb_bsg_wormhole_router_output_control.sv
module tb_bsg_wormhole_router_output_control;

  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [N-1:0] reqs_i, release_i, valid_i;
  logic         ready_i;
  logic         valid_o, busy_o;
  logic [N-1:0] grant_o, yumi_o;

  logic         reset5;
  logic [4:0]   reqs5, release5, valid5;
  logic         ready5;
  logic         valid5_o, busy5_o;
  logic [4:0]   grant5_o, yumi5_o;

  always #5 clk_i = ~clk_i;

  bsg_wormhole_router_output_control #(.input_dirs_p(N)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .reqs_i(reqs_i), .release_i(release_i),
    .valid_i(valid_i), .ready_i(ready_i), .valid_o(valid_o), .grant_o(grant_o),
    .yumi_o(yumi_o), .busy_o(busy_o));

  bsg_wormhole_router_output_control #(.input_dirs_p(5)) dut5 (
    .clk_i(clk_i), .reset_i(reset5), .reqs_i(reqs5), .release_i(release5),
    .valid_i(valid5), .ready_i(ready5), .valid_o(valid5_o), .grant_o(grant5_o),
    .yumi_o(yumi5_o), .busy_o(busy5_o));

  typedef struct packed {
    logic [N-1:0] grant;
    logic [N-1:0] yumi;
    logic         valid;
    logic         busy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = none), header-pending flag, priority pointer
  int m_owner = -1;
  bit m_pend  = 0;
  int m_ptr   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic [N-1:0] rq, rl, vl, input logic rd,
                            output exp_t e);
    int w;
    e = '0;
    if (rst) begin
      m_owner = -1; m_pend = 0; m_ptr = 0;
      return;
    end
    e.busy = (m_owner >= 0);
    if (m_owner < 0 || (!m_pend && rl[m_owner])) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        e.grant = N'(1) << w;
        e.valid = 1'b1;
        e.yumi  = rd ? e.grant : '0;
        m_owner = w;
        m_pend  = !rd;
        if (rd) m_ptr = (w + 1) % N;
      end else begin
        m_owner = -1;
        m_pend  = 0;
      end
    end else if (m_pend) begin
      e.grant = N'(1) << m_owner;
      e.valid = 1'b1;
      e.yumi  = rd ? e.grant : '0;
      if (rd) begin
        m_pend = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end else begin
      e.grant = N'(1) << m_owner;
      e.valid = vl[m_owner];
      e.yumi  = (vl[m_owner] && rd) ? e.grant : '0;
    end
  endtask

  // Apply one cycle of inputs shortly after the rising edge and queue the expectation
  task automatic drive(input logic rst, input logic [N-1:0] rq, rl, vl, input logic rd);
    exp_t e;
    @(posedge clk_i); #1;
    reset_i = rst; reqs_i = rq; release_i = rl; valid_i = vl | rq; ready_i = rd;
    model_step(rst, rq, rl, vl | rq, rd, e);
    q.push_back(e);
  endtask

  // Monitor: compare presented outputs mid-cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("grant", 32'(grant_o), 32'(e.grant));
        chk("yumi",  32'(yumi_o),  32'(e.yumi));
        chk("valid", 32'(valid_o), 32'(e.valid));
        chk("busy",  32'(busy_o),  32'(e.busy));
      end
    end
  end

  task automatic drive5(input logic rst, input logic [4:0] rq, input logic rd);
    @(posedge clk_i); #1;
    reset5 = rst; reqs5 = rq; release5 = 5'b11111; valid5 = rq; ready5 = rd;
    #1;
  endtask

  initial begin
    int budget;
    logic [N-1:0] rq, rl, vl;
    reset_i = 1'b1; reqs_i = '0; release_i = '1; valid_i = '0; ready_i = 1'b0;
    reset5 = 1'b1; reqs5 = '0; release5 = '1; valid5 = '0; ready5 = 1'b0;

    // First header after reset
    drive(1, 4'b0000, 4'b1111, 4'b0000, 1);
    drive(0, 4'b0001, 4'b1111, 4'b0000, 1);
    // Contention among zero-payload packets
    repeat (5) drive(0, 4'b1011, 4'b1111, 4'b0000, 1);
    // Backpressure on a presented header
    drive(1, 4'b0000, 4'b1111, 4'b0000, 1);
    drive(0, 4'b0100, 4'b1111, 4'b0000, 0);
    drive(0, 4'b0101, 4'b1111, 4'b0000, 0);
    drive(0, 4'b0101, 4'b1111, 4'b0000, 0);
    drive(0, 4'b0101, 4'b1111, 4'b0000, 1);
    drive(0, 4'b1001, 4'b1111, 4'b0000, 1);
    // Locked body with toggling valid, competing request ignored
    drive(1, 4'b0000, 4'b1111, 4'b0000, 1);
    drive(0, 4'b0010, 4'b1111, 4'b0000, 1);
    drive(0, 4'b0001, 4'b1101, 4'b0010, 1);
    drive(0, 4'b0001, 4'b1101, 4'b0000, 1);
    drive(0, 4'b0001, 4'b1101, 4'b0010, 1);
    drive(0, 4'b0001, 4'b1101, 4'b0010, 1);
    drive(0, 4'b0001, 4'b1111, 4'b0000, 1);
    // Asynchronous reset while locked to input 2
    drive(1, 4'b0000, 4'b1111, 4'b0000, 1);
    drive(0, 4'b0100, 4'b1111, 4'b0000, 1);
    drive(0, 4'b0000, 4'b1011, 4'b0100, 1);
    drive(1, 4'b0100, 4'b1011, 4'b0100, 1);
    #1;
    chk("async_rst_grant", 32'(grant_o), 32'h0);
    chk("async_rst_valid", 32'(valid_o), 32'h0);
    chk("async_rst_busy",  32'(busy_o),  32'h0);
    drive(0, 4'b0100, 4'b1111, 4'b0000, 1);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      rq = 4'($urandom) & 4'($urandom);
      rl = 4'($urandom) | 4'($urandom);
      vl = 4'($urandom);
      drive(($urandom_range(0, 99) == 0), rq, rl, vl, ($urandom_range(0, 9) < 7));
    end
    drive(1, 4'b0000, 4'b1111, 4'b0000, 1);

    // Five-port instance: pointer at 4 wraps to 0
    drive5(1, 5'b00000, 1);
    drive5(0, 5'b01000, 1);
    chk("p5_first", 32'(grant5_o), 32'h08);
    drive5(0, 5'b10001, 1);
    chk("p5_wrap_grant", 32'(grant5_o), 32'h10);
    chk("p5_wrap_yumi",  32'(yumi5_o),  32'h10);
    drive5(0, 5'b10001, 1);
    chk("p5_after_wrap", 32'(grant5_o), 32'h01);
    chk("p5_busy", 32'(busy5_o), 32'h1);

    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk_i);
      budget++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_wormhole_router_output_control.md
Name: bsg_wormhole_router_output_control

Overview:
- Per-output-direction controller for the wormhole router; one instance sits at each output port, receiving the requests from all input controls.
- Arbitrates round-robin among input ports whose header flit requests this output, then locks the grant to the winner until that input's packet has fully drained.
- Drives crossbar select, downstream valid, and per-input yumi; downstream uses valid/ready.

Parameters:
- input_dirs_p, 4, number of input ports competing for this output (>=2).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous reset, active-high.
- reqs_i  in  input_dirs_p  bit k: input k's head flit is a header destined here (valid header).
- release_i  in  input_dirs_p  bit k: input k has no packet in flight (its payload counter is zero).
- valid_i  in  input_dirs_p  bit k: input k FIFO has a valid head flit.
- ready_i  in  1  downstream can accept a flit this cycle.
- valid_o  out  1  flit presented downstream.
- grant_o  out  input_dirs_p  one-hot crossbar select; all-zero when nothing is granted.
- yumi_o  out  input_dirs_p  one-hot dequeue to the granted input.
- busy_o  out  1  high in PEND or LOCK.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, priority pointer=0 (input 0 highest), grant_r=0. Outputs: valid_o=0, grant_o=0, yumi_o=0, busy_o=0.
- State register: IDLE, PEND, LOCK. grant_r holds the one-hot owner in PEND/LOCK.
- Arbitration (combinational, "free" condition): free = IDLE, or LOCK with release_i[owner]=1.
  - When free, the winner is the first set bit of reqs_i, scanning from the pointer upward with wrap.
  - grant_o=winner; valid_o=|reqs_i.
- Header acceptance when free and winner exists:
  - If ready_i=1: yumi_o=winner; pointer<=index(winner)+1 mod input_dirs_p; state<=LOCK; grant_r<=winner.
  - If ready_i=0: yumi_o=0; state<=PEND; grant_r<=winner; pointer unchanged.
- Free with no reqs: state<=IDLE; grant_r<=0.
- PEND:
  - grant_o=grant_r; valid_o=1. A header already presented stays granted; later higher-priority requests are ignored.
  - yumi_o=grant_r&ready_i.
  - On ready_i=1: pointer advances past the owner; state<=LOCK.
  - release_i is ignored in PEND.
- LOCK with release_i[owner]=0:
  - grant_o=grant_r; valid_o=valid_i[owner]; yumi_o=grant_r&{valid_i[owner]&ready_i}.
  - No arbitration; reqs_i from other inputs are ignored.
- LOCK with release_i[owner]=1 (packet drained, including zero-payload packets one cycle after their header): unlock and arbitrate in the same cycle per the free rules. No bubble cycle; the previous owner competes at lowest priority.
- Invariants:
  - yumi_o only asserts with valid_o&ready_i.
  - yumi_o is a subset of grant_o.
  - grant_o is one-hot or zero.
- Throughput: one flit/cycle while ready_i=1; back-to-back packets from different inputs with zero idle cycles.
- reset_i asserted mid-packet: immediate return to IDLE/pointer 0. Upstream input controls reset together; no partial-packet recovery.
- Ports with reqs_i=1 while valid_i=0 are a protocol violation. Assert in simulation only.
- Widths: pointer is $clog2(input_dirs_p) bits; wrap is explicit for non-power-of-2 input_dirs_p.

Test Plan:
- Reset then reqs_i=0001, release_i=1111, ready_i=1 → same cycle grant_o=0001, yumi_o=0001, valid_o=1; next state LOCK, pointer=1.
- Contention: reqs_i=1011 held, each packet of 0 payload, ready_i=1 → header grants in order 0001,0010,1000,0001 on consecutive headers with no idle cycles.
- Backpressure on header: reqs_i=0100, ready_i=0 for 3 cycles, reqs_i 0001 asserted in cycle 2 → grant_o stays 0100, yumi_o=0000, busy_o=1. When ready_i=1, yumi_o=0100 and pointer=3.
- Locked body: input 1 header, release_i[1]=0 for 3 body flits, valid_i[1] toggling 1,0,1,1, reqs_i=0001 meanwhile → grant_o=0010 throughout, yumi_o=0010 only on valid&ready cycles. Input 0 is granted in the cycle release_i[1] returns 1.
- Async reset during LOCK (owner 2) → outputs zero immediately with no clock edge; after release, reqs_i=0100 → grant_o=0100 again, pointer restarts at 0.
- Non-power-of-2: input_dirs_p=5, pointer=4, reqs_i=10001 → winner 10000, then pointer wraps to 0 → next winner 00001.
